// File: rtl/io_lectura_if.sv
// CPU/UART-side bundle for the I/O read path: receive strobe and byte,
// CPU read strobe and register index, and the returned read data plus status.
interface io_lectura_if #(
  parameter int T = 8,
  parameter int N = 5
);
  logic         rx_valid;
  logic [T-1:0] rx_data;
  logic         habilitar;
  logic [N-1:0] entradaDeco;
  logic [T-1:0] salidaLectura;
  logic         rx_listo;
  logic         desborde;

  modport master (
    output rx_valid, rx_data, habilitar, entradaDeco,
    input  salidaLectura, rx_listo, desborde
  );

  modport slave (
    input  rx_valid, rx_data, habilitar, entradaDeco,
    output salidaLectura, rx_listo, desborde
  );
endinterface

// File: rtl/io_lectura.sv
// CPU read side of the I/O space: a small FIFO buffering UART bytes, exposed
// as DATO (pop), ESTADO (clear-on-read overflow) and CUENTA read registers.
module io_lectura #(
  parameter int T    = 8,
  parameter int PROF = 4,
  parameter int N    = 5
) (
  input  logic         clk,
  input  logic         rst,
  io_lectura_if.slave  bus
);

  localparam int AW = $clog2(PROF);
  localparam int CW = $clog2(PROF) + 1;

  localparam logic [N-1:0] IDX_DATO   = N'(0);
  localparam logic [N-1:0] IDX_ESTADO = N'(1);
  localparam logic [N-1:0] IDX_CUENTA = N'(2);

  logic [T-1:0]  mem [PROF];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [T-1:0]  salida_q;
  logic          desborde_q;

  logic          empty, full;
  logic          read_dato, read_estado;
  logic          pop, push, overflow;
  logic [T-1:0]  rd_val;

  assign empty       = (count == '0);
  assign full        = (count == CW'(PROF));
  assign read_dato   = bus.habilitar && (bus.entradaDeco == IDX_DATO);
  assign read_estado = bus.habilitar && (bus.entradaDeco == IDX_ESTADO);

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign pop      = read_dato && !empty;
  assign push     = bus.rx_valid && (!full || pop);
  assign overflow = bus.rx_valid && full && !pop;

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    rd_val = '0;
    case (bus.entradaDeco)
      IDX_DATO:   rd_val = empty ? '0 : mem[rd_ptr];
      IDX_ESTADO: rd_val[2:0] = {desborde_q, full, !empty};
      IDX_CUENTA: rd_val = T'(count);
      default:    rd_val = '0;
    endcase
  end

  // NOTE: storage is left unreset; pointers and count alone define valid entries.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= bus.rx_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      salida_q   <= '0;
      desborde_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (bus.habilitar) salida_q <= rd_val;

      // An overflow in the same cycle as an ESTADO read wins over the clear.
      if (overflow)         desborde_q <= 1'b1;
      else if (read_estado) desborde_q <= 1'b0;
    end
  end

  assign bus.salidaLectura = salida_q;
  assign bus.rx_listo      = !empty;
  assign bus.desborde      = desborde_q;

endmodule

// File: tb/tb_io_lectura.sv
// Self-checking bench for io_lectura: directed scenarios followed by random
// traffic, all compared against a queue-based model of the register map.
module tb_io_lectura;
  localparam int T    = 8;
  localparam int PROF = 4;
  localparam int N    = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_lectura_if #(.T(T), .N(N)) bus ();

  io_lectura #(.T(T), .PROF(PROF), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [T-1:0] q[$];
  logic [T-1:0] m_out;
  logic         m_desb;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, advance the model across the edge, then compare.
  task automatic step(input logic r, input logic rv, input logic [T-1:0] d,
                      input logic hab, input logic [N-1:0] idx);
    int  sz;
    bit  popped;
    @(negedge clk);
    rst             = r;
    bus.rx_valid    = rv;
    bus.rx_data     = d;
    bus.habilitar   = hab;
    bus.entradaDeco = idx;
    @(posedge clk);
    sz = q.size();
    if (r) begin
      q.delete();
      m_out  = '0;
      m_desb = 1'b0;
    end else begin
      popped = hab && (idx == 0) && (sz > 0);
      if (hab) begin
        case (int'(idx))
          0:       m_out = (sz > 0) ? q[0] : '0;
          1:       m_out = T'({m_desb, sz == PROF, sz != 0});
          2:       m_out = T'(sz);
          default: m_out = '0;
        endcase
      end
      if (rv && sz == PROF && !popped) m_desb = 1'b1;
      else if (hab && idx == 1)        m_desb = 1'b0;
      if (popped) void'(q.pop_front());
      if (rv && (sz < PROF || popped)) q.push_back(d);
    end
    #1;
    check("salidaLectura", 32'(bus.salidaLectura), 32'(m_out));
    check("rx_listo",      32'(bus.rx_listo),      32'(q.size() != 0));
    check("desborde",      32'(bus.desborde),      32'(m_desb));
  endtask

  task automatic push(input logic [T-1:0] d);
    step(1'b0, 1'b1, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [N-1:0] idx);
    step(1'b0, 1'b0, '0, 1'b1, idx);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.habilitar = 1'b0; bus.entradaDeco = '0;
    m_out = '0; m_desb = 1'b0;

    // Reset state
    step(1'b1, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    rd(5'd1);
    check("reset_estado", 32'(bus.salidaLectura), 32'h00);

    // Two bytes in, two DATO reads out, then CUENTA
    push(8'h41);
    push(8'h42);
    rd(5'd0); check("dato_first", 32'(bus.salidaLectura), 32'h41);
    idle();   check("dato_hold",  32'(bus.salidaLectura), 32'h41);
    rd(5'd0); check("dato_second", 32'(bus.salidaLectura), 32'h42);
    rd(5'd2); check("cuenta_empty", 32'(bus.salidaLectura), 32'h00);
    check("listo_empty", 32'(bus.rx_listo), 32'h0);

    // Overflow: fifth byte dropped, ESTADO reports and clears it
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    check("desborde_set", 32'(bus.desborde), 32'h1);
    rd(5'd1); check("estado_ovf", 32'(bus.salidaLectura), 32'h06 | 32'h01);
    check("desborde_clr", 32'(bus.desborde), 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(5'd0); check("dato_ovf", 32'(bus.salidaLectura), 32'(8'h10 + i));
    end

    // Full FIFO: push alongside DATO read is not an overflow
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    step(1'b0, 1'b1, 8'h55, 1'b1, 5'd0);
    check("full_pushpop", 32'(bus.salidaLectura), 32'h20);
    check("full_no_ovf",  32'(bus.desborde), 32'h0);
    rd(5'd2); check("full_cuenta", 32'(bus.salidaLectura), 32'h04);
    for (int i = 0; i < 4; i++) rd(5'd0);
    check("last_55", 32'(bus.salidaLectura), 32'h55);

    // Empty reads and an unmapped index
    rd(5'd0); check("empty_dato", 32'(bus.salidaLectura), 32'h00);
    rd(5'd2); check("empty_cuenta", 32'(bus.salidaLectura), 32'h00);
    push(8'h99);
    rd(5'd7); check("idx7", 32'(bus.salidaLectura), 32'h00);
    rd(5'd2); check("idx7_no_effect", 32'(bus.salidaLectura), 32'h01);
    rd(5'd0);

    // Empty + push + pop: pop returns 0, push is kept
    step(1'b0, 1'b1, 8'h77, 1'b1, 5'd0);
    check("empty_pushpop", 32'(bus.salidaLectura), 32'h00);
    rd(5'd2); check("empty_pushpop_cnt", 32'(bus.salidaLectura), 32'h01);
    rd(5'd0);

    // Overflow in the same cycle as an ESTADO read
    for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
    step(1'b0, 1'b1, 8'hEE, 1'b1, 5'd1);
    check("estado_ovf_same", 32'(bus.salidaLectura), 32'h03);
    check("set_wins", 32'(bus.desborde), 32'h1);
    for (int i = 0; i < 4; i++) rd(5'd0);
    rd(5'd1);

    // Pointer wrap-around
    for (int i = 0; i < 10; i++) begin
      push(8'(8'hA0 + i));
      rd(5'd0); check("wrap", 32'(bus.salidaLectura), 32'(8'hA0 + i));
    end

    // Reset mid-stream with pending traffic ignored
    push(8'hB0);
    push(8'hB1);
    step(1'b1, 1'b1, 8'hB2, 1'b1, 5'd0);
    rd(5'd2); check("rst_cuenta", 32'(bus.salidaLectura), 32'h00);
    check("rst_listo", 32'(bus.rx_listo), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 1)),
           8'($urandom),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
